pipeline_ex1: RTL and testbench

- Three-stage arithmetic pipeline computing F = ((A + B) + (C - D)) * D on N-bit unsigned operands.
- Throughput is one result per clock; latency is 3 register stages.
- Used as a building-block/teaching datapath.
- Pure datapath: no valid/ready handshake, no stalls.

---
 rtl/pipeline_ex1_pkg.sv | 8 +
 rtl/pipeline_ex1_pipe_reg.sv | 16 +
 rtl/pipeline_ex1.sv | 40 ++++
 tb/tb_pipeline_ex1.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipeline_ex1_pkg.sv
// Shared constants for the pipeline_ex1 datapath: default operand width and
// register-stage count (used to align latency when comparing results).
package pipeline_ex1_pkg;

  localparam int PIPE_W      = 10;
  localparam int PIPE_STAGES = 3;

endpackage

// File: rtl/pipeline_ex1_pipe_reg.sv
// Parameterised-width stage register with synchronous active-high clear.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/pipeline_ex1.sv
// Three-stage datapath F = ((A + B) + (C - D)) * D, all arithmetic mod 2^N,
// one result per clock, no handshake; reset clears every stage.
module pipeline_ex1
  import pipeline_ex1_pkg::*;
#(
  parameter int N = PIPE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  output logic [N-1:0] F
);

  logic [N-1:0] s1_x1_d, s1_x2_d;
  logic [N-1:0] s1_x1, s1_x2, s1_d;
  logic [N-1:0] s2_x3_d;
  logic [N-1:0] s2_x3, s2_d;
  logic [N-1:0] f_d;

  // N-bit targets keep only the low bits, giving the mod 2^N wrap for free.
  always_comb begin
    s1_x1_d = A + B;
    s1_x2_d = C - D;
    s2_x3_d = s1_x1 + s1_x2;
    f_d     = s2_x3 * s2_d;
  end

  pipe_reg #(.W(N)) u_s1_x1 (.clk(clk), .rst(rst), .d(s1_x1_d), .q(s1_x1));
  pipe_reg #(.W(N)) u_s1_x2 (.clk(clk), .rst(rst), .d(s1_x2_d), .q(s1_x2));
  pipe_reg #(.W(N)) u_s1_d  (.clk(clk), .rst(rst), .d(D),       .q(s1_d));

  pipe_reg #(.W(N)) u_s2_x3 (.clk(clk), .rst(rst), .d(s2_x3_d), .q(s2_x3));
  pipe_reg #(.W(N)) u_s2_d  (.clk(clk), .rst(rst), .d(s1_d),    .q(s2_d));

  pipe_reg #(.W(N)) u_s3_f  (.clk(clk), .rst(rst), .d(f_d),     .q(F));

endmodule

// File: tb/tb_pipeline_ex1.sv
// Bench for pipeline_ex1: directed and random operand streams compared after
// every edge against a history-based model of F.
module tb_pipeline_ex1;
  import pipeline_ex1_pkg::*;

  localparam int N   = PIPE_W;
  localparam int MOD = 1 << N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [N-1:0] f;

  typedef struct {
    int a, b, c, d;
    bit r;
  } vec_t;

  vec_t hist[$];
  int   nvec = 0;
  int   nerr = 0;

  pipeline_ex1 #(.N(N)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d), .F(f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Result after edge n: any reset within the last PIPE_STAGES edges zeroes it,
  // otherwise it is the formula on the set sampled PIPE_STAGES-1 edges earlier.
  function automatic int model_f(int n);
    int s;
    for (int k = n - PIPE_STAGES + 1; k <= n; k++)
      if (k < 0 || hist[k].r) return 0;
    s = hist[n - PIPE_STAGES + 1].a + hist[n - PIPE_STAGES + 1].b
      + hist[n - PIPE_STAGES + 1].c - hist[n - PIPE_STAGES + 1].d + 2 * MOD;
    return (s * hist[n - PIPE_STAGES + 1].d) % MOD;
  endfunction

  task automatic step(input string tag, input int va, input int vb, input int vc,
                      input int vd, input bit vr);
    vec_t v;
    @(negedge clk);
    a = N'(va); b = N'(vb); c = N'(vc); d = N'(vd); rst = vr;
    v.a = va % MOD; v.b = vb % MOD; v.c = vc % MOD; v.d = vd % MOD; v.r = vr;
    @(posedge clk);
    hist.push_back(v);
    #1;
    chk($sformatf("%s@%0d", tag, hist.size() - 1), f, N'(model_f(hist.size() - 1)));
  endtask

  initial begin
    int sets[11][4] = '{
      '{1, 1, 1, 1}, '{5, 2, 1, 1}, '{5, 3, 3, 1}, '{6, 6, 6, 2}, '{2, 1, 1, 1},
      '{1, 0, 0, 1}, '{100, 0, 0, 3}, '{500, 500, 0, 0}, '{1000, 0, 0, 2},
      '{1023, 1023, 0, 1023}, '{0, 0, 1023, 0}
    };
    int exp_f[11] = '{2, 7, 10, 32, 3, 0, 291, 0, 972, 1, 0};

    // reset with arbitrary operands, then zeros
    step("rst", 77, 300, 12, 9, 1'b1);
    step("post_rst0", 0, 0, 0, 0, 1'b0);
    step("post_rst1", 0, 0, 0, 0, 1'b0);

    // directed stream with wrap/truncation cases, back to back
    for (int i = 0; i < 11; i++)
      step("dir", sets[i][0], sets[i][1], sets[i][2], sets[i][3], 1'b0);
    step("drain0", 0, 0, 0, 0, 1'b0);
    step("drain1", 0, 0, 0, 0, 1'b0);
    // explicit spot checks of hand-computed results: set i lands after edge 3+i+2
    for (int i = 0; i < 11; i++) begin
      int s, n;
      n = 3 + i + 2;
      s = sets[i][0] + sets[i][1] + sets[i][2] - sets[i][3] + 2 * MOD;
      chk($sformatf("hand%0d", i), N'(exp_f[i]), N'((s * sets[i][3]) % MOD));
      chk($sformatf("model%0d", i), N'(model_f(n)), N'(exp_f[i]));
    end

    // mid-stream reset after the 2nd set
    step("mid", 1, 1, 1, 1, 1'b0);
    step("mid", 5, 2, 1, 1, 1'b0);
    step("mid_rst", 5, 3, 3, 1, 1'b1);
    step("mid", 6, 6, 6, 2, 1'b0);
    step("mid", 2, 1, 1, 1, 1'b0);
    step("mid", 100, 0, 0, 3, 1'b0);
    step("mid", 0, 0, 0, 0, 1'b0);
    step("mid", 0, 0, 0, 0, 1'b0);

    // input hold
    for (int i = 0; i < 5; i++) step("hold", 6, 6, 6, 2, 1'b0);
    chk("hold_final", f, 10'd32);

    // random stream with occasional resets
    for (int i = 0; i < 300; i++)
      step("rnd", $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
           $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
           ($urandom_range(0, 29) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
